// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: parity encodings,
// receiver FSM states and a small elaboration helper.
package uart_rx_cfg_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// rx pad synchroniser plus a three-deep oversample history; maj_bit is the
// majority of the two previous s_tick samples and the current rx_s.
module uart_rx_cfg_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic s_tick,
  output logic rx_s,
  output logic maj_bit
);

  logic [SYNC_STAGES-1:0] sync;
  logic [1:0]             hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      hist <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (s_tick) hist <= {hist[0], rx_s};
    end
  end

  assign rx_s    = sync[SYNC_STAGES-1];
  assign maj_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DBIT data bits LSB first, optional parity,
// programmable stop length, majority-vote sampling and line-break detection.
//
// state       | meaning
// ST_IDLE     | line idle, waiting for rx_s low
// ST_START    | timing to start-bit centre, glitch rejection
// ST_DATA     | shifting in DBIT data bits
// ST_PARITY   | sampling the parity bit
// ST_STOP     | stop period, frame report at its last tick
// ST_BRK_WAIT | break reported, waiting for line to return high
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int OS_TICKS    = 16,
  parameter int PARITY      = 0,
  parameter int STOP_TICKS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] data_out,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  localparam int TW = $clog2(max_int(OS_TICKS, STOP_TICKS));
  localparam int BW = $clog2(DBIT + 1);
  // Decisions land one tick after the nominal centre so the vote window
  // (MID-1, MID, MID+1) is complete; all later bit boundaries inherit that.
  localparam logic [TW-1:0] T_VOTE     = TW'(OS_TICKS / 2);
  localparam logic [TW-1:0] T_BIT_END  = TW'(OS_TICKS - 1);
  localparam logic [TW-1:0] T_STOP_END = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] B_LAST     = BW'(DBIT - 1);

  rx_state_t       state, state_next;
  logic [TW-1:0]   tick_cnt, tick_next;
  logic [BW-1:0]   bit_cnt, bit_next;
  logic [DBIT-1:0] data_sh, sh_next;
  logic            par_bit, par_next;
  logic            perr_q, perr_next;
  logic            ferr_q, ferr_next;
  logic            ferr_now, brk_now, finish;
  logic            rx_s, maj_bit;

  uart_rx_cfg_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .s_tick  (s_tick),
    .rx_s    (rx_s),
    .maj_bit (maj_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    sh_next    = data_sh;
    par_next   = par_bit;
    perr_next  = perr_q;
    ferr_next  = ferr_q;
    ferr_now   = ferr_q;
    brk_now    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        tick_next = '0;
        if (!rx_s) state_next = ST_START;
      end
      ST_START: if (s_tick) begin
        if (tick_cnt == T_VOTE) begin
          tick_next = '0;
          bit_next  = '0;
          state_next = maj_bit ? ST_IDLE : ST_DATA;
        end else tick_next = tick_cnt + 1'b1;
      end
      ST_DATA: if (s_tick) begin
        if (tick_cnt == T_BIT_END) begin
          tick_next = '0;
          sh_next   = {maj_bit, data_sh[DBIT-1:1]};
          if (bit_cnt == B_LAST)
            state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_next = bit_cnt + 1'b1;
        end else tick_next = tick_cnt + 1'b1;
      end
      ST_PARITY: if (s_tick) begin
        if (tick_cnt == T_BIT_END) begin
          tick_next  = '0;
          par_next   = maj_bit;
          perr_next  = (PARITY == PARITY_EVEN) ? (maj_bit != ^data_sh)
                                               : (maj_bit != ~^data_sh);
          state_next = ST_STOP;
        end else tick_next = tick_cnt + 1'b1;
      end
      ST_STOP: if (s_tick) begin
        // With one stop bit the vote tick and the final tick coincide.
        if (tick_cnt == T_BIT_END) begin
          ferr_now  = ~maj_bit;
          ferr_next = ~maj_bit;
        end
        if (tick_cnt == T_STOP_END) begin
          finish     = 1'b1;
          tick_next  = '0;
          brk_now    = ferr_now && (data_sh == '0) &&
                       ((PARITY == PARITY_NONE) || !par_bit);
          state_next = brk_now ? ST_BRK_WAIT : ST_IDLE;
        end else tick_next = tick_cnt + 1'b1;
      end
      ST_BRK_WAIT: if (rx_s) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      data_sh      <= '0;
      par_bit      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_done_tick <= 1'b0;
      break_det    <= 1'b0;
      data_out     <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      tick_cnt     <= tick_next;
      bit_cnt      <= bit_next;
      data_sh      <= sh_next;
      par_bit      <= par_next;
      perr_q       <= perr_next;
      ferr_q       <= ferr_next;
      rx_done_tick <= finish;
      break_det    <= brk_now;
      if (finish) begin
        data_out   <= data_sh;
        parity_err <= perr_q;
        frame_err  <= ferr_now;
      end
    end
  end

endmodule
